// File: rtl/router_ingress_ctrl.sv
// Ingress packet controller for the 1x3 router: sequences header decode, payload,
// parity load/check and drives the write-side controls of the synchroniser/FIFO stage.
module router_ingress_ctrl #(
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              busy,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg
);

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP               = 4'd8
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_INV = '1;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] addr_sel;
    logic              sel_empty;
    logic              sel_srst;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= DECODE_ADDRESS;
            dest  <= ADDR_INV;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && pkt_valid)
                dest <= data_in;
        end
    end

    // While decoding, the header byte on data_in has not reached dest yet.
    always_comb begin
        addr_sel = (state == DECODE_ADDRESS) ? data_in : dest;
        if (addr_sel == ADDR_W'(0))      sel_empty = fifo_empty_0;
        else if (addr_sel == ADDR_W'(1)) sel_empty = fifo_empty_1;
        else if (addr_sel == ADDR_W'(2)) sel_empty = fifo_empty_2;
        else                             sel_empty = 1'b0;

        if (dest == ADDR_W'(0))          sel_srst = soft_reset_0;
        else if (dest == ADDR_W'(1))     sel_srst = soft_reset_1;
        else if (dest == ADDR_W'(2))     sel_srst = soft_reset_2;
        else                             sel_srst = 1'b0;
    end

    always_comb begin
        next_state    = state;
        busy          = 1'b0;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;

        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                if (pkt_valid) begin
                    if (data_in == ADDR_INV) next_state = DROP;
                    else if (sel_empty)      next_state = LOAD_FIRST_DATA;
                    else                     next_state = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: begin
                lfd_state  = 1'b1;
                busy       = 1'b1;
                next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                if (fifo_full)       next_state = FIFO_FULL_STATE;
                else if (!pkt_valid) next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
                if (!fifo_full) next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                busy          = 1'b1;
                write_enb_reg = 1'b1;
                if (parity_done)        next_state = DECODE_ADDRESS;
                else if (low_pkt_valid) next_state = LOAD_PARITY;
                else                    next_state = LOAD_DATA;
            end
            LOAD_PARITY: begin
                busy          = 1'b1;
                write_enb_reg = 1'b1;
                next_state    = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                busy        = 1'b1;
                rst_int_reg = 1'b1;
                next_state  = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
                if (sel_empty) next_state = LOAD_FIRST_DATA;
            end
            DROP: begin
                if (!pkt_valid) next_state = DECODE_ADDRESS;
            end
            default: next_state = DECODE_ADDRESS;
        endcase

        // A read timeout on the addressed output abandons the packet from any active state.
        if (state != DECODE_ADDRESS && state != DROP && sel_srst)
            next_state = DECODE_ADDRESS;
    end

endmodule
